// File: rtl/irq_pending_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared constants, FSM state type and priority helper for the
//                interrupt pending latch.
//                Contents:
//                  N_REQ        number of request lines (8)
//                  IDX_W        width of a request index (3)
//                  irq_state_t  presentation FSM state (IDLE / PRESENT)
//                  prio_idx()   index of the highest set bit (bit 7 wins)
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

  // Highest set bit wins, matching the downstream encoder ordering.
  // Returns 0 for an all-zero vector; callers qualify with a separate valid.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_pending_latch_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync2
//  Description : Single-bit two-flop synchronizer, flops reset to 0.
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                d      asynchronous input bit
//                q      synchronized output bit (2 clk latency)
//  Revision    : 1.0  initial release
// ============================================================================
module irq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_latch
//  Description : Captures rising edges on 8 request lines into a pending
//                register, selects the highest-priority unmasked pending line
//                and presents its index on a valid/ready handshake. Accepted
//                lines are cleared; edges on already-pending lines set sticky
//                overflow flags.
//  Build macro : IRQ_SYNC_EN - when defined, every req bit is passed through a
//                two-flop synchronizer before edge detection (+2 cycles).
//  Ports       : clk      system clock
//                rst_n    asynchronous active-low reset
//                req      level request lines (rising edge registers)
//                mask     1 = line excluded from selection (still captured)
//                out_vld  index valid
//                out_rdy  consumer ready
//                out_idx  index of the presented request
//                pending  current pending register
//                ovf      sticky per-line overflow flags
//                ovf_clr  one-cycle pulse clearing all ovf flags
//  Revision    : 1.0  initial release
// ============================================================================
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf,
  input  logic             ovf_clr
);

  localparam logic [N_REQ-1:0] C_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] w_req_s;
  logic [N_REQ-1:0] r_req_q;
  logic [N_REQ-1:0] w_edge;
  logic [N_REQ-1:0] w_clear;
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_ovf_set;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_ovf;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_next_vld;
  logic             w_xfer;
  logic             w_load;
  irq_state_t       r_state;
  irq_state_t       w_state_nxt;

  // --------------------------------------------------------------------------
  // Request conditioning
  // --------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
    irq_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req[gi]),
      .q     (w_req_s[gi])
    );
  end
`else
  assign w_req_s = req;
`endif

  // --------------------------------------------------------------------------
  // Edge detect, clear, overflow and candidate selection
  // --------------------------------------------------------------------------
  assign w_edge = w_req_s & ~r_req_q;
  assign w_xfer = out_vld & out_rdy;

  // One-hot of the line being handed off this cycle.
  assign w_clear = w_xfer ? (C_ONE << r_idx) : '0;

  // Re-arm of the line being accepted is a fresh request, not a lost one.
  assign w_ovf_set = w_edge & r_pending & ~w_clear;

  // The accepted line is excluded so back-to-back transfers never repeat it.
  assign w_cand     = r_pending & ~mask & ~w_clear;
  assign w_next_vld = |w_cand;
  assign w_next_idx = prio_idx(w_cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      r_req_q   <= w_req_s;
      r_pending <= w_edge | (r_pending & ~w_clear);
      r_ovf     <= w_ovf_set | (ovf_clr ? '0 : r_ovf);
    end
  end

  // --------------------------------------------------------------------------
  // Presentation FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_idx <= w_next_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Presentation FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_next_vld) w_state_nxt = PRESENT;
      // Held while stalled: no preemption by newer or higher requests.
      PRESENT: if (out_rdy)    w_state_nxt = w_next_vld ? PRESENT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Presentation FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_vld = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE:    w_load = w_next_vld;
      PRESENT: begin
        out_vld = 1'b1;
        w_load  = out_rdy & w_next_vld;
      end
      default: begin
        out_vld = 1'b0;
        w_load  = 1'b0;
      end
    endcase
  end

  assign out_idx = r_idx;
  assign pending = r_pending;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_pending_latch
//  Description : Randomized + directed scoreboard bench for irq_pending_latch.
//                A behavioural model predicts per-cycle state and the index of
//                every handshake; a negedge monitor pops and compares.
//                Honours IRQ_SYNC_EN (adds the two-cycle request delay).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_vld;
  logic       out_rdy;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic [7:0] ovf;
  logic       ovf_clr;

  irq_pending_latch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_idx (out_idx),
    .pending (pending),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         vld;
    int         idx;
    logic [7:0] pend;
    logic [7:0] ovf;
  } exp_t;

  exp_t sq[$];   // expected state after each edge
  int   xq[$];   // expected index of each handshake

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  bit   m_pend [8];
  bit   m_ovf  [8];
  int   m_pres;           // presented line, -1 when nothing shown
  logic [7:0] m_hist [3]; // [0],[1] sync stages, [2] previous effective req

  function automatic logic [7:0] pack(input bit v [8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_pres = -1;
    for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] m,
                            input bit rd, input bit cl, output exp_t e);
    int         acc;
    int         np;
    logic [7:0] eff;
    bit         edg;
    bit         np_pend [8];
    bit         np_ovf  [8];
    acc = (m_pres >= 0 && rd) ? m_pres : -1;
    if (acc >= 0) xq.push_back(acc);
    eff = SYNC ? m_hist[1] : r;
    for (int i = 0; i < 8; i++) begin
      edg        = eff[i] && !m_hist[2][i];
      np_pend[i] = edg || (m_pend[i] && i != acc);
      np_ovf[i]  = (edg && m_pend[i] && i != acc) || (m_ovf[i] && !cl);
    end
    // A new choice is made only when idle or when the shown line is taken.
    if (m_pres < 0 || acc >= 0) begin
      np = -1;
      for (int i = 7; i >= 0; i--) begin
        if (np < 0 && m_pend[i] && !m[i] && i != acc) np = i;
      end
      m_pres = np;
    end
    m_pend    = np_pend;
    m_ovf     = np_ovf;
    m_hist[2] = eff;
    m_hist[1] = m_hist[0];
    m_hist[0] = r;
    e.vld  = (m_pres >= 0);
    e.idx  = m_pres;
    e.pend = pack(m_pend);
    e.ovf  = pack(m_ovf);
  endtask

  // One clock cycle with the given inputs.
  task automatic cyc(input logic [7:0] r, input logic [7:0] m,
                     input bit rd, input bit cl);
    exp_t e;
    req = r; mask = m; out_rdy = rd; ovf_clr = cl;
    model_step(r, m, rd, cl, e);
    @(posedge clk);
    sq.push_back(e);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit rd);
    for (int k = 0; k < n; k++) cyc(8'h00, 8'h00, rd, 1'b0);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_x;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld && out_rdy) begin
        chk("xfer_expected", int'(xq.size() > 0), 1);
        if (xq.size() > 0) begin
          mon_x = xq.pop_front();
          chk("xfer_idx", int'(out_idx), mon_x);
        end
      end
      if (sq.size() > 0) begin
        mon_e = sq.pop_front();
        chk("out_vld", int'(out_vld), int'(mon_e.vld));
        chk("pending", int'(pending), int'(mon_e.pend));
        chk("ovf",     int'(ovf),     int'(mon_e.ovf));
        if (mon_e.vld) chk("out_idx", int'(out_idx), mon_e.idx);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r_m;
    rst_n = 1'b0; req = '0; mask = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ovf",     int'(ovf),     0);
    rst_n = 1'b1;

    // single request on line 5
    idle_cycles(2, 1'b1);
    cyc(8'h20, 8'h00, 1'b1, 1'b0);
    idle_cycles(6, 1'b1);

    // priority order and back-to-back transfers
    cyc(8'h91, 8'h00, 1'b1, 1'b0);
    idle_cycles(8, 1'b1);

    // all lines pending at once
    cyc(8'hFF, 8'h00, 1'b1, 1'b0);
    idle_cycles(12, 1'b1);

    // stall with no preemption
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    idle_cycles(4, 1'b0);
    cyc(8'h40, 8'h00, 1'b0, 1'b0);
    idle_cycles(4, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // masking
    cyc(8'h88, 8'h80, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(8'h00, 8'h80, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // overflow, clear, and same-cycle set/clear
    cyc(8'h02, 8'h00, 1'b0, 1'b0);
    idle_cycles(4, 1'b0);
    cyc(8'h02, 8'h00, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    idle_cycles(2, 1'b0);
    // line 1 is presented here; its re-arm lands on the accept edge
    // (the synchronizer build shifts this, the model tracks either way)
    cyc(8'h02, 8'h00, 1'b1, 1'b0);
    idle_cycles(4, 1'b0);
    idle_cycles(5, 1'b1);

    // async reset while presenting with overflow set
    cyc(8'h01, 8'h00, 1'b0, 1'b0);
    idle_cycles(4, 1'b0);
    cyc(8'h01, 8'h00, 1'b0, 1'b0);
    idle_cycles(4, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", int'(out_vld), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_ovf",     int'(ovf),     0);
    sq.delete();
    xq.delete();
    model_reset();
    req = '0; out_rdy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    r_m = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) r_m = 8'($urandom) & 8'($urandom);
      cyc(8'($urandom) & 8'($urandom), r_m,
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    idle_cycles(20, 1'b1);
    @(negedge clk);
    #1;
    chk("state_queue_drained", sq.size(), 0);
    chk("xfer_queue_drained",  xq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream capture-and-present stage for the 8-to-3 priority encoder path.
- Latches rising edges on 8 request lines into a pending register and applies a mask.
- Selects the highest-priority pending request (bit 7 highest, matching the encoder ordering) and presents its 3-bit index on a valid/ready handshake.
- Clears the serviced pending bit on acceptance; flags lost requests in sticky overflow bits.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 for the 3-bit index.
- IDX_W, 3, index width, equal to clog2(N_REQ).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  level request lines; only a rising edge registers a request.
- mask  in  8  1 = line disabled for selection; pending bits still capture.
- out_vld  out  1  index valid.
- out_rdy  in  1  consumer ready; transfer when out_vld && out_rdy at a clk edge.
- out_idx  out  3  index of the selected request.
- pending  out  8  current pending register.
- ovf  out  8  sticky per-line overflow flags.
- ovf_clr  in  1  one-cycle pulse; clears all ovf bits.

Behaviour:
- Reset (async assert, sync release): out_vld=0, out_idx=0, pending=0, ovf=0, req_q=0.
- Edge detect: edge = req & ~req_q. req_q <= req every cycle.
- Pending update per bit i, each edge:
  - Clear term: i == out_idx && out_vld && out_rdy.
  - pending[i] <= edge[i] | (pending[i] & ~clear[i]).
  - A set on the same cycle as a clear wins; the bit stays pending.
- Overflow:
  - ovf[i] <= 1 when edge[i] && pending[i] && !clear[i].
  - ovf_clr clears all bits; a same-cycle set wins over ovf_clr.
- Selection: cand = pending & ~mask & ~clear. The highest set bit of cand gives next_idx; any set bit gives next_vld.
- Two-state FSM, IDLE (out_vld=0) and PRESENT (out_vld=1):
  - IDLE -> PRESENT when next_vld; out_idx <= next_idx.
  - PRESENT with !out_rdy: hold. out_idx and out_vld stay stable even if a higher-priority request arrives or mask changes. No preemption.
  - PRESENT with out_rdy: if next_vld, stay in PRESENT and load next_idx; this gives back-to-back transfers at one per cycle. Otherwise go to IDLE.
- Latency: req rises before edge k -> pending set at edge k -> out_vld/out_idx valid after edge k+1.
- Masking a line while its index is presented does not withdraw the index.
- All 8 pending with out_rdy=1: indices 7,6,...,0 on 8 consecutive cycles.
- Reset mid-handshake: all state is dropped immediately; nothing is retained.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: each req bit passes through a 2-flop synchronizer (reset to 0) before edge detect. Latency grows by 2 cycles, so out_vld is valid after edge k+3.
- Undefined: req is assumed synchronous to clk and used directly.

Decomposition:
- Shared package irq_pkg:
  - constants N_REQ=8, IDX_W=3;
  - state typedef irq_state_t {IDLE, PRESENT};
  - function prio_idx(8-bit) returning highest set index.
- One sub-module: irq_sync2, the per-bit 2-flop synchronizer, instantiated only under IRQ_SYNC_EN. Selection logic stays inline.

Test Plan:
- Reset then single request: after reset, pulse req[5] high for 1 cycle, out_rdy=1 -> pending=0x20 after edge k; out_vld=1, out_idx=5 after edge k+1; pending=0x00 and out_vld=0 one cycle later.
- Priority and back-to-back: req 0x00->0x91 in one cycle, out_rdy=1 -> out_idx sequence 7,4,0 on consecutive cycles, then out_vld=0 and pending=0.
- Stall and no preemption: pending 0x04, out_rdy=0 with idx 2 presented; raise req[6] -> out_idx stays 2 while stalled. After out_rdy=1 for one cycle, the next index is 6.
- Mask: mask=0x80, req edges on 7 and 3 -> only idx 3 presented. Pending stays 0x80; clear mask -> idx 7 presented next.
- Overflow and same-cycle set/clear: second edge on req[1] while pending[1]=1 and not accepted -> ovf=0x02; ovf_clr pulse -> ovf=0. Edge on req[1] in the accept cycle of idx 1 -> pending[1] remains 1, ovf stays 0, idx 1 re-presented.
- Async reset mid-PRESENT: assert rst_n=0 between clk edges -> out_vld, pending, ovf go 0 without a clk edge. With IRQ_SYNC_EN, the single-request test shows out_vld after edge k+3.
